// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the handshaked EX-stage ALU.
//   - 4-bit op-code constants (ALU_AND .. ALU_MUL); codes 11xx are undefined.
//   - FSM state encoding used by alu_pipe_hs.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : latch a/b and begin (ignored while reset is high)
//   a, b         : multiplicand / multiplier (WIDTH bits, unsigned)
//   busy         : an operation is in flight
//   done         : high during the last step cycle; product is final then
//   product      : 2*WIDTH-bit product, valid while done is high
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;

  // product is the accumulator after the current step, so the top level can
  // register the final value on the same edge the last step completes.
  assign product = acc + (b_sh[0] ? a_sh : '0);
  assign done    = busy & (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      acc  <= '0;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
    end else if (busy) begin
      acc  <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: EX-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops register their result on the accept edge; MUL runs in the
// iterative multiplier and registers its result when the last step finishes.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : operation handshake (accept = in_valid & in_ready)
//   input1, input2        : operands; input2[SHW-1:0] is the shift amount
//   ALUControl            : 4-bit op code
//   out_valid / out_ready : result handshake
//   result                : registered WIDTH-bit result
//   zero, negative, carry, overflow, illegal : registered status flags
module alu_pipe_hs #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  import alu_pkg::*;

  state_t state, state_nxt;

  logic accept, is_mul, mul_start, mul_busy, mul_done;
  logic load_alu, load_mul;
  logic [2*WIDTH-1:0] mul_product;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          sum_w, diff_w;
  logic [SHW-1:0]          shamt;

  logic [WIDTH-1:0] alu_res, res_nxt;
  logic alu_carry, alu_ovf, alu_ill;
  logic carry_nxt, ovf_nxt, ill_nxt;

  // Signed overflow: same-sign addends yielding a result of the other sign.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow for a - b: differing signs and result sign differs from a.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (input1),
    .b       (input2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath, evaluated on the live operands at the accept edge.
  always_comb begin
    a_s       = input1;
    b_s       = input2;
    shamt     = input2[SHW-1:0];
    sum_w     = {1'b0, input1} + {1'b0, input2};
    diff_w    = {1'b0, input1} - {1'b0, input2};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (ALUControl)
      ALU_AND:  alu_res = input1 & input2;
      ALU_OR:   alu_res = input1 | input2;
      ALU_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = add_ovf(input1[WIDTH-1], input2[WIDTH-1], sum_w[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
        alu_ovf   = sub_ovf(input1[WIDTH-1], input2[WIDTH-1], diff_w[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      ALU_XOR:  alu_res = input1 ^ input2;
      ALU_NOR:  alu_res = ~(input1 | input2);
      ALU_SLL:  alu_res = input1 << shamt;
      ALU_SRL:  alu_res = input1 >> shamt;
      ALU_SRA:  alu_res = a_s >>> shamt;
      ALU_MUL:  alu_res = '0;
      default:  alu_ill = 1'b1;
    endcase
  end

  // Handshake and next-state logic.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase

    accept    = in_valid & in_ready;
    is_mul    = (ALUControl == ALU_MUL);
    mul_start = accept & is_mul;

    case (state)
      S_IDLE: if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
      S_MUL: begin
        if (mul_done)       state_nxt = S_DONE;
        // An idle multiplier without done cannot deliver; do not hang here.
        else if (!mul_busy) state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (accept)         state_nxt = is_mul ? S_MUL : S_DONE;
        else if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    load_alu  = accept & ~is_mul;
    load_mul  = (state == S_MUL) & mul_done;
    res_nxt   = load_mul ? mul_product[WIDTH-1:0] : alu_res;
    carry_nxt = load_mul ? 1'b0 : alu_carry;
    ovf_nxt   = load_mul ? (|mul_product[2*WIDTH-1:WIDTH]) : alu_ovf;
    ill_nxt   = load_mul ? 1'b0 : alu_ill;
  end

  // Output register stage: result and flags captured together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_alu | load_mul) begin
        result   <= res_nxt;
        zero     <= (res_nxt == '0);
        negative <= res_nxt[WIDTH-1];
        carry    <= carry_nxt;
        overflow <= ovf_nxt;
        illegal  <= ill_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// tb_alu_pipe_hs: directed self-checking bench for alu_pipe_hs (WIDTH=16).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, so a value seen there is what the next rising edge will observe.
// Flag vectors are ordered {zero, negative, carry, overflow, illegal}.
module tb_alu_pipe_hs;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] input1;
  logic [15:0] input2;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero, negative, carry, overflow, illegal;

  int n_chk  = 0;
  int n_fail = 0;
  int lat;
  logic busy_ok;

  alu_pipe_hs #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input1     (input1),
    .input2     (input2),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: present an op, confirm it can be taken, let the
  // next rising edge accept it, and return at the following falling edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input string tag);
    ALUControl = op;
    input1     = a;
    input2     = b;
    in_valid   = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp_res,
                            input logic [4:0] exp_flags, input string tag);
    issue(op, a, b, tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, "_flags"}, {27'd0, zero, negative, carry, overflow, illegal},
        {27'd0, exp_flags});
    @(negedge clock);
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic [4:0] exp_flags,
                         input string tag);
    issue(4'b1011, a, b, tag);
    // Operands changed after accept must not disturb the multiply.
    input1     = 16'hFFFF;
    input2     = 16'hFFFF;
    ALUControl = 4'b0010;
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_busy_in_ready"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, "_flags"}, {27'd0, zero, negative, carry, overflow, illegal},
        {27'd0, exp_flags});
    @(negedge clock);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    input1     = 16'h0;
    input2     = 16'h0;
    ALUControl = 4'h0;

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {27'd0, zero, negative, carry, overflow, illegal}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single-cycle ops
    run_single(4'b0010, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010, "add_ovf");
    chk("add_ovf_drained", {31'd0, out_valid}, 32'd0);
    run_single(4'b0010, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100, "add_carry");
    run_single(4'b0011, 16'h0003, 16'h0005, 16'hFFFE, 5'b01100, "sub_borrow");
    run_single(4'b0011, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, "sub_ovf");
    run_single(4'b0100, 16'hFFFF, 16'h0001, 16'h0001, 5'b00000, "slt");
    run_single(4'b0101, 16'hFFFF, 16'h0001, 16'h0000, 5'b10000, "sltu");
    run_single(4'b1010, 16'h8000, 16'h0013, 16'hF000, 5'b01000, "sra");
    run_single(4'b1000, 16'h0001, 16'h000F, 16'h8000, 5'b01000, "sll");
    run_single(4'b1001, 16'h8000, 16'h000F, 16'h0001, 5'b00000, "srl");
    run_single(4'b0110, 16'hFF00, 16'h0FF0, 16'hF0F0, 5'b01000, "xor");
    run_single(4'b0111, 16'h0F0F, 16'h00F0, 16'hF000, 5'b01000, "nor");

    // Multiplier
    run_mul(16'h0100, 16'h0100, 16'h0000, 5'b10010, "mul_big");
    run_mul(16'd12, 16'd13, 16'h009C, 5'b00000, "mul_small");

    // Backpressure, then back-to-back accept with no bubble
    out_ready = 1'b0;
    issue(4'b0010, 16'd2, 16'd3, "bp_add");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_result", {16'd0, result}, 32'd5);
      chk("bp_hold_in_ready", {30'd0, in_ready, out_valid}, 32'd1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    issue(4'b0000, 16'hF0F0, 16'h0FF0, "b2b_and");
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", {16'd0, result}, 32'h00F0);
    @(negedge clock);

    // Reset in the middle of a multiply
    issue(4'b1011, 16'd12, 16'd13, "rst_mul");
    for (int i = 0; i < 5; i++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid) busy_ok = 1'b0;
    end
    chk("midrst_discarded", {31'd0, busy_ok}, 32'd1);

    // Undefined op code, then a legal op clears illegal
    run_single(4'b1100, 16'h1234, 16'h5678, 16'h0000, 5'b10001, "illegal");
    run_single(4'b0001, 16'h1200, 16'h0034, 16'h1234, 5'b00000, "or_after_ill");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
